// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and the tick-divider calculation.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Clocks per oversample tick; never below one so the divider stays legal.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via clear.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver with oversampled mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic sync_p0, sync_p1, prev_p2;
    logic tick, start_clr;

    uart_state_t            state, state_nxt;
    logic [CW-1:0]          tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic [7:0]             data_nxt;
    logic                   valid_nxt, frame_err_nxt, parity_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad, par_bad_nxt;
`endif

    // Synchroniser stage plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= IDLE_LEVEL;
            sync_p1 <= IDLE_LEVEL;
            prev_p2 <= IDLE_LEVEL;
        end else begin
            sync_p0 <= rx;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_clr),
        .tick  (tick)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick ? tick_cnt + CW'(1) : tick_cnt;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        data_nxt       = data;
        valid_nxt      = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        start_clr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt    = par_bad;
`endif
        case (state)
            IDLE: begin
                if (prev_p2 == IDLE_LEVEL && sync_p1 != IDLE_LEVEL) begin
                    state_nxt    = START;
                    tick_cnt_nxt = '0;
                    start_clr    = 1'b1;
                end
            end
            START: begin
                if (tick && tick_cnt == HALF_LAST) begin
                    tick_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = (sync_p1 == IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tick_cnt == BIT_LAST) begin
                    tick_cnt_nxt = '0;
                    shreg_nxt    = {sync_p1, shreg[DATA_BITS-1:1]};
                    bit_cnt_nxt  = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && tick_cnt == BIT_LAST) begin
                    tick_cnt_nxt = '0;
                    par_bad_nxt  = (sync_p1 != ^shreg);
                    state_nxt    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && tick_cnt == BIT_LAST) begin
                    tick_cnt_nxt = '0;
                    if (sync_p1 == IDLE_LEVEL) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_nxt = par_bad;
`endif
                        state_nxt = IDLE;
                    end else begin
                        // Low stop bit: hold off until the line recovers so a break cannot retrigger.
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (sync_p1 == IDLE_LEVEL) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= 8'h00;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            data       <= data_nxt;
            valid      <= valid_nxt;
            frame_err  <= frame_err_nxt;
            parity_err <= parity_err_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
// Honours UART_RX_PARITY_EN to match the DUT frame format.
module tb_uart_rx;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int OS          = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS  = 11;
`else
    localparam int FRAME_BITS  = 10;
`endif
    // Strobe is due half a bit into the stop bit, measured from the start edge.
    localparam int STROBE_LAT  = FRAME_BITS * OS - OS / 2;

    typedef struct {
        logic       v;
        logic       f;
        logic       p;
        logic [7:0] d;
        int         t0;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   n_perr = 0;
    int   last_valid = -1;
    int   busy_from = -1;
    int   busy_to = -2;
    logic [7:0] exp_data = 8'h00;
    ev_t  exp_q[$];

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok, output int t0);
        ev_t e;
        t0 = cyc + 1;
        e.v  = stop_ok;
        e.f  = !stop_ok;
        e.d  = b;
        e.t0 = t0;
`ifdef UART_RX_PARITY_EN
        e.p  = stop_ok && !par_ok;
`else
        e.p  = 1'b0;
`endif
        exp_q.push_back(e);
        busy_from = t0 + 4;
        busy_to   = t0 + STROBE_LAT - 4;
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(b[i], OS);
`ifdef UART_RX_PARITY_EN
        hold(par_ok ? ^b : ~^b, OS);
`endif
        hold(stop_ok, OS);
    endtask

    // Compare process: strobes against the expected-event queue, held data and busy window.
    initial begin
        ev_t e;
        int  d;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (valid || frame_err || parity_err) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_strobe", int'({valid, frame_err, parity_err}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_kind", int'({valid, frame_err, parity_err}), int'({e.v, e.f, e.p}));
                        d = cyc - e.t0;
                        chk("strobe_delay", (d >= STROBE_LAT - 3 && d <= STROBE_LAT + 3) ? STROBE_LAT : d, STROBE_LAT);
                        if (e.v) exp_data = e.d;
                    end
                    if (valid) begin
                        n_valid++;
                        last_valid = cyc;
                    end
                    if (frame_err) n_ferr++;
                    if (parity_err) n_perr++;
                end else if (exp_q.size() > 0 && cyc > exp_q[0].t0 + STROBE_LAT + 3) begin
                    e = exp_q.pop_front();
                    chk("missing_strobe", 0, int'({e.v, e.f, e.p}));
                end
                chk("data_held", int'(data), int'(exp_data));
                if (cyc >= busy_from && cyc <= busy_to) chk("busy_in_frame", int'(busy), 1);
            end
        end
    end

    initial begin
        int t0;
        int gap;
        logic [7:0] b;
        logic so, po;
        logic [7:0] hello [5];
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 20);

        // Single clean frame
        send_frame(8'h48, 1'b1, 1'b1, t0);
        hold(1'b1, 20);
        chk("t1_data", int'(data), 8'h48);
        chk("t1_valid_count", n_valid, 1);
        chk("t1_delay_window", (last_valid - t0 >= 149 && last_valid - t0 <= 155) ? 1 : 0, 1);
        chk("t1_frame_err_count", n_ferr, 0);

        // Start-bit glitch
        hold(1'b0, 4);
        chk("t2_busy_on_glitch", int'(busy), 1);
        hold(1'b1, 8);
        chk("t2_busy_released", int'(busy), 0);
        hold(1'b1, 20);
        chk("t2_valid_count", n_valid, 1);

        // Framing error followed by a long break
        send_frame(8'h55, 1'b0, 1'b1, t0);
        hold(1'b0, 100);
        hold(1'b1, 20);
        chk("t3_data_kept", int'(data), 8'h48);
        chk("t3_frame_err_count", n_ferr, 1);
        chk("t3_valid_count", n_valid, 1);
        chk("t3_busy_idle", int'(busy), 0);

        // Back-to-back "Hello"
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, 1'b1, t0);
        hold(1'b1, 30);
        chk("t4_valid_count", n_valid, 6);
        chk("t4_last_data", int'(data), 8'h6F);

        // Reset during data bit 3 of 0xA5
        hold(1'b0, OS);
        hold(1'b1, OS);
        hold(1'b0, OS);
        hold(1'b1, OS);
        hold(1'b0, OS / 2);
        rst = 1'b0;
        rx  = 1'b1;
        exp_q.delete();
        exp_data  = 8'h00;
        busy_from = -1;
        busy_to   = -2;
        @(posedge clk);
        @(negedge clk);
        chk("t5_data_zero", int'(data), 0);
        chk("t5_valid_zero", int'(valid), 0);
        chk("t5_frame_err_zero", int'(frame_err), 0);
        chk("t5_parity_err_zero", int'(parity_err), 0);
        chk("t5_busy_zero", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        hold(1'b1, 40);
        send_frame(8'h3C, 1'b1, 1'b1, t0);
        hold(1'b1, 20);
        chk("t5_recovered_data", int'(data), 8'h3C);

`ifdef UART_RX_PARITY_EN
        // Parity: bad parity still loads data; good parity gives valid only
        send_frame(8'h07, 1'b1, 1'b0, t0);
        hold(1'b1, 20);
        chk("t6_data", int'(data), 8'h07);
        chk("t6_parity_err_count", n_perr, 1);
        send_frame(8'h07, 1'b1, 1'b1, t0);
        hold(1'b1, 20);
        chk("t6_parity_err_unchanged", n_perr, 1);
`endif

        // Random frames with random gaps and occasional framing errors
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            so  = ($urandom_range(0, 7) != 0);
            po  = ($urandom_range(0, 3) != 0);
            gap = so ? int'($urandom_range(0, 12)) : int'($urandom_range(8, 20));
            send_frame(b, so, po, t0);
            hold(1'b1, gap);
        end
        hold(1'b1, 200);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
